// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared types, widths and address check for dmem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int unsigned C_WORD_W = 32;
    localparam int unsigned C_STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Misaligned or beyond the last word of storage.
    function automatic logic addr_error(input logic [C_WORD_W-1:0] addr,
                                        input int unsigned          depth_words);
        logic [C_WORD_W-1:0] w_idx;
        w_idx = {2'b00, addr[C_WORD_W-1:2]};
        return (addr[1:0] != 2'b00) || (w_idx >= C_WORD_W'(depth_words));
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_array.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_array
// Description : Word storage with byte-lane writes and a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256
) (
    input  logic                           clk,
    input  logic                           i_we,
    input  logic                           i_re,
    input  logic [$clog2(DEPTH_WORDS)-1:0] i_idx,
    input  logic [C_WORD_W-1:0]            i_wdata,
    input  logic [C_STRB_W-1:0]            i_wstrb,
    output logic [C_WORD_W-1:0]            o_rdata
);

    logic [C_WORD_W-1:0] r_mem [DEPTH_WORDS];

    // Contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < int'(C_STRB_W); i++) begin
                if (i_wstrb[i]) begin
                    r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
        if (i_re) begin
            o_rdata <= r_mem[i_idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory slave with valid/ready request and response and
//               a fixed number of wait states per access.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [C_WORD_W-1:0] req_addr,
    input  logic [C_WORD_W-1:0] req_wdata,
    input  logic [C_STRB_W-1:0] req_wstrb,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [C_WORD_W-1:0] rsp_rdata,
    output logic                rsp_error
);

    localparam int unsigned C_IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  C_LAT   = 4'(LATENCY);

    state_t              r_state, w_state_nxt;
    logic [3:0]          r_cnt, w_cnt_nxt;
    logic                r_write;
    logic [C_WORD_W-1:0] r_addr, r_wdata;
    logic [C_STRB_W-1:0] r_wstrb;
    logic                r_rsp_load, r_rsp_error;

    logic                w_accept, w_enter_resp, w_commit;
    logic                w_op_write, w_op_err, w_we, w_re;
    logic [C_WORD_W-1:0] w_op_addr, w_op_wdata, w_arr_rdata;
    logic [C_STRB_W-1:0] w_op_wstrb;

    assign req_ready = (r_state == IDLE) && !reset;
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (C_LAT == 4'd0) begin
                        w_state_nxt  = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = C_LAT;
                    end
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt  = RESP;
                    w_enter_resp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // With zero latency the access commits on the accepting edge, so the
    // live request fields are used instead of the latched copy.
    assign w_op_write = (r_state == IDLE) ? req_write : r_write;
    assign w_op_addr  = (r_state == IDLE) ? req_addr  : r_addr;
    assign w_op_wdata = (r_state == IDLE) ? req_wdata : r_wdata;
    assign w_op_wstrb = (r_state == IDLE) ? req_wstrb : r_wstrb;
    assign w_op_err   = addr_error(w_op_addr, DEPTH_WORDS);

    assign w_commit = w_enter_resp && !reset;
    assign w_we     = w_commit && w_op_write && !w_op_err;
    assign w_re     = w_commit && !w_op_write && !w_op_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= 4'd0;
            r_rsp_load  <= 1'b0;
            r_rsp_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_commit) begin
                r_rsp_load  <= !w_op_write && !w_op_err;
                r_rsp_error <= w_op_err;
            end else if ((r_state == RESP) && rsp_ready) begin
                r_rsp_load  <= 1'b0;
                r_rsp_error <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write <= req_write;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wstrb <= req_wstrb;
        end
    end

    dmem_responder_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_re    (w_re),
        .i_idx   (w_op_addr[C_IDX_W+1:2]),
        .i_wdata (w_op_wdata),
        .i_wstrb (w_op_wstrb),
        .o_rdata (w_arr_rdata)
    );

    assign rsp_valid = (r_state == RESP);
    assign rsp_rdata = r_rsp_load ? w_arr_rdata : '0;
    assign rsp_error = r_rsp_error;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dmem_responder
// Description : Scoreboard bench for dmem_responder (LATENCY 2 and 0 copies).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic        req_valid, req_write, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_ready, rsp_valid, rsp_error;
    logic [31:0] rsp_rdata;

    logic        zreq_valid, zreq_write, zrsp_ready;
    logic [31:0] zreq_addr, zreq_wdata;
    logic [3:0]  zreq_wstrb;
    logic        zreq_ready, zrsp_valid, zrsp_error;
    logic [31:0] zrsp_rdata;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_dut_z (
        .clk(clk), .reset(reset),
        .req_valid(zreq_valid), .req_ready(zreq_ready), .req_write(zreq_write),
        .req_addr(zreq_addr), .req_wdata(zreq_wdata), .req_wstrb(zreq_wstrb),
        .rsp_valid(zrsp_valid), .rsp_ready(zrsp_ready),
        .rsp_rdata(zrsp_rdata), .rsp_error(zrsp_error)
    );

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        sb_z[$];
    logic [31:0] model [0:255];
    int          tests_run    = 0;
    int          tests_failed = 0;

    function automatic bit tb_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'd256);
    endfunction

    function automatic exp_t predict(input bit wr, input logic [31:0] a,
                                     input logic [31:0] wd, input logic [3:0] st);
        exp_t        e;
        logic [31:0] w;
        e.err   = tb_err(a);
        e.rdata = 32'h0;
        if (!e.err) begin
            if (wr) begin
                w = model[a[9:2]];
                for (int i = 0; i < 4; i++) if (st[i]) w[8*i +: 8] = wd[8*i +: 8];
                model[a[9:2]] = w;
            end else begin
                e.rdata = model[a[9:2]];
            end
        end
        return e;
    endfunction

    // Drive a request until accepted; push its expectation when tracked.
    task automatic send_req(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] st, input bit track);
        bit acc;
        acc       = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_wstrb = st;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin
                @(posedge clk); #1;
                acc = 1'b1;
            end
        end
        req_valid = 1'b0;
        if (!acc) begin
            tests_run++; tests_failed++;
            $display("FAIL req_accept timeout addr=%h", a);
        end else if (track) begin
            sb.push_back(predict(wr, a, wd, st));
        end
    endtask

    // Accept one response; lat counts cycles from the accepting edge.
    task automatic wait_rsp(output logic [31:0] rd, output logic er, output int lat,
                            output bit ok);
        ok = 1'b0; lat = 0; rd = '0; er = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid === 1'b1) begin
                rd = rsp_rdata;
                er = rsp_error;
                @(posedge clk); #1;
                ok = 1'b1;
            end
        end
        rsp_ready = 1'b0;
        if (!ok) begin
            tests_run++; tests_failed++;
            $display("FAIL rsp_wait timeout");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0; rsp_ready = 0;
        zreq_valid = 0; zreq_write = 0; zreq_addr = 0; zreq_wdata = 0; zreq_wstrb = 0;
        zrsp_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({req_ready, rsp_valid, rsp_error, rsp_rdata} !== 35'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs got ready=%b valid=%b err=%b rdata=%h exp all 0",
                     req_ready, rsp_valid, rsp_error, rsp_rdata);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if ({req_ready, zreq_ready} !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_release_ready got=%b%b exp=11", req_ready, zreq_ready);
        end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat; bit ok; exp_t e;
        send_req(1'b1, 32'h10, 32'hA1B2C3D4, 4'hF, 1'b1);
        wait_rsp(rd, er, lat, ok);
        e = sb.pop_front();
        tests_run++;
        if (lat !== 3) begin
            tests_failed++; $display("FAIL t1_latency got=%0d exp=3", lat);
        end
        tests_run++;
        if ({rd, er} !== {e.rdata, e.err}) begin
            tests_failed++; $display("FAIL t1_store_rsp got=%h/%b exp=%h/%b", rd, er, e.rdata, e.err);
        end
        send_req(1'b0, 32'h10, 32'h0, 4'h0, 1'b1);
        wait_rsp(rd, er, lat, ok);
        e = sb.pop_front();
        tests_run++;
        if ({rd, er} !== {e.rdata, e.err} || rd !== 32'hA1B2C3D4) begin
            tests_failed++; $display("FAIL t1_load got=%h/%b exp=%h/%b", rd, er, e.rdata, e.err);
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd; logic er; int lat; bit ok; exp_t e;
        logic [31:0] a_wd [4] = '{32'h000000EE, 32'h0, 32'hFFFFFFFF, 32'h0};
        logic [3:0]  a_st [4] = '{4'h1, 4'h0, 4'h0, 4'h0};
        bit          a_wr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            send_req(a_wr[k], 32'h10, a_wd[k], a_st[k], 1'b1);
            wait_rsp(rd, er, lat, ok);
            e = sb.pop_front();
            tests_run++;
            if ({rd, er} !== {e.rdata, e.err}) begin
                tests_failed++;
                $display("FAIL t2_step%0d got=%h/%b exp=%h/%b", k, rd, er, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; bit ok; exp_t e;
        logic [31:0] a_addr [4] = '{32'h0, 32'h13, 32'h400, 32'h0};
        bit          a_wr   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int k = 0; k < 4; k++) begin
            send_req(a_wr[k], a_addr[k], 32'h12345678 + 32'(k), 4'hF, 1'b1);
            wait_rsp(rd, er, lat, ok);
            e = sb.pop_front();
            tests_run++;
            if ({rd, er} !== {e.rdata, e.err} || lat !== 3) begin
                tests_failed++;
                $display("FAIL t3_step%0d got=%h/%b lat=%0d exp=%h/%b lat=3",
                         k, rd, er, lat, e.rdata, e.err);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er; int lat; bit ok, seen; exp_t e;
        send_req(1'b1, 32'h30, 32'h0BADCAFE, 4'hF, 1'b1);
        wait_rsp(rd, er, lat, ok);
        e = sb.pop_front();
        send_req(1'b0, 32'h30, 32'h0, 4'h0, 1'b1);
        e = sb.pop_front();
        rsp_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++; $display("FAIL t4_rsp_valid timeout");
        end
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            tests_run++;
            if ({rsp_valid, req_ready, rsp_rdata, rsp_error} !== {1'b1, 1'b0, e.rdata, e.err}) begin
                tests_failed++;
                $display("FAIL t4_hold_c%0d got v=%b rdy=%b %h/%b exp v=1 rdy=0 %h/%b",
                         c, rsp_valid, req_ready, rsp_rdata, rsp_error, e.rdata, e.err);
            end
            if (c == 5) begin
                @(posedge clk); #1;
                rsp_ready = 1'b1;
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        tests_run++;
        if ({req_ready, rsp_valid, rsp_rdata, rsp_error} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            tests_failed++;
            $display("FAIL t4_after_hs got rdy=%b v=%b %h/%b exp rdy=1 v=0 0/0",
                     req_ready, rsp_valid, rsp_rdata, rsp_error);
        end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; logic er; int lat; bit ok; exp_t e;
        send_req(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1);
        wait_rsp(rd, er, lat, ok);
        e = sb.pop_front();
        send_req(1'b1, 32'h20, 32'h55555555, 4'hF, 1'b0);
        reset = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 1'b0) begin
            tests_failed++; $display("FAIL t5_ready_in_reset got=%b exp=0", req_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        tests_run++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            tests_failed++; $display("FAIL t5_after_reset got v=%b rdy=%b exp v=0 rdy=1", rsp_valid, req_ready);
        end
        send_req(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);
        wait_rsp(rd, er, lat, ok);
        e = sb.pop_front();
        tests_run++;
        if ({rd, er} !== {e.rdata, e.err} || rd !== 32'hCAFEF00D) begin
            tests_failed++; $display("FAIL t5_old_value got=%h/%b exp=%h/%b", rd, er, e.rdata, e.err);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e; bit acc, prev_acc; int n_acc;
        zreq_valid = 1'b1; zreq_write = 1'b1; zreq_addr = 32'h8;
        zreq_wdata = 32'hDEADBEEF; zreq_wstrb = 4'hF;
        prev_acc = 1'b0; n_acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tests_run++;
            if (zrsp_valid !== prev_acc) begin
                tests_failed++; $display("FAIL t6_rsp_timing c%0d got=%b exp=%b", c, zrsp_valid, prev_acc);
            end
            if (zrsp_valid === 1'b1 && sb_z.size() > 0) begin
                e = sb_z.pop_front();
                tests_run++;
                if ({zrsp_rdata, zrsp_error} !== {e.rdata, e.err}) begin
                    tests_failed++;
                    $display("FAIL t6_rsp_data c%0d got=%h/%b exp=%h/%b", c, zrsp_rdata, zrsp_error, e.rdata, e.err);
                end
            end
            acc = zreq_valid && (zreq_ready === 1'b1);
            if (acc) begin
                n_acc++;
                e.err   = 1'b0;
                e.rdata = zreq_write ? 32'h0 : 32'hDEADBEEF;
                sb_z.push_back(e);
            end
            prev_acc = acc;
            @(posedge clk); #1;
            if (acc) zreq_write = 1'b0;
        end
        zreq_valid = 1'b0;
        tests_run++;
        if (n_acc !== 5) begin
            tests_failed++; $display("FAIL t6_accept_rate got=%0d exp=5", n_acc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_store_load();
        test_partial_store();
        test_errors();
        test_backpressure();
        test_reset_in_wait();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory port, the slave end of the load/store path.
- Accepts one word-sized request at a time over a valid/ready handshake and inserts a configurable number of wait states.
- Performs byte-masked writes or word reads on internal storage, then returns a response over a second valid/ready handshake.
- Replaces the zero-latency DMEM when the core is moved to a stalling memory interface.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words of storage; must be a power of two, at least 2.
- LATENCY, 2, wait-state cycles between acceptance and response; legal range 0..15.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  responder can accept a request
- req_write  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, little-endian lanes
- req_wstrb  input  4  byte-lane write enables; ignored for loads
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts response
- rsp_rdata  output  32  load data; 0 for stores and errors
- rsp_error  output  1  access was misaligned or out of range

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset: state is IDLE, wait counter is 0, rsp_valid is 0, rsp_rdata is 0, rsp_error is 0. req_ready is 0 while reset is high and 1 in the first cycle after reset drops.
- Storage is not cleared by reset. Reset never modifies storage.
- IDLE:
  - req_ready = 1.
  - On a cycle with req_valid & req_ready, latch write, addr, wdata and wstrb.
  - LATENCY = 0: go to RESP.
  - Otherwise: load counter = LATENCY and go to WAIT.
- WAIT:
  - req_ready = 0.
  - Counter decrements each cycle.
  - When the counter equals 1, go to RESP on the next edge.
  - Request inputs are ignored.
- Access commit: occurs on the edge that enters RESP.
  - Store: lanes with wstrb[i] = 1 update bits 8i+7:8i. wstrb = 0 is a legal no-op.
  - Load: rsp_rdata is registered from storage on the same edge.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_error are held stable until the handshake.
  - On rsp_ready = 1, go to IDLE, and rsp_valid, rsp_rdata and rsp_error clear to 0 on that edge.
  - rsp_ready is a don't-care outside RESP.
- Latency: for a request accepted at edge E, rsp_valid is high from edge E + LATENCY onward. The next request can be accepted no earlier than the cycle after the response handshake. Minimum period is LATENCY + 2 cycles.
- Errors: an error is req_addr[1:0] != 0, or the word index req_addr[31:2] >= DEPTH_WORDS. On an error, storage is not written, rsp_rdata = 0, rsp_error = 1, and the timing is unchanged.
- Index: the storage index is req_addr[log2(DEPTH_WORDS)+1:2], used only when the access is in range.
- Reset mid-transaction: a request in WAIT is discarded and its store is never committed. A pending response in RESP is dropped.
- Read-after-write: a load accepted after a store's response handshake returns the stored data. There is no forwarding path because only one request is outstanding.

Decomposition:
- Shared package (dmem_pkg):
  - state enum {IDLE, WAIT, RESP}
  - word width 32
  - strobe width 4
  - function for the address-error check
- One sub-module: dmem_responder_array. It is the synchronous storage with a byte-lane write enable and a registered word read port, instantiated once.
- The FSM, counter and response registers stay in the top module.

Test Plan:
1. LATENCY = 2. Store addr 0x10, wdata 0xA1B2C3D4, wstrb 0xF, accepted at edge 0 -> rsp_valid high from edge 2, rsp_error 0, rsp_rdata 0. Then a load of 0x10 -> rsp_rdata 0xA1B2C3D4.
2. Partial store to 0x10 with wdata 0x000000EE, wstrb 0x1, then load 0x10 -> 0xA1B2C3EE. Store with wstrb 0x0 -> word unchanged, rsp_error 0.
3. Load 0x13 (misaligned), and a store to 0x400 with DEPTH_WORDS = 256 -> rsp_error 1, rsp_rdata 0. A following load of 0x0 returns its prior value unchanged.
4. Response backpressure: hold rsp_ready low for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready 0 throughout. Handshake on cycle 6 -> req_ready 1 on the next cycle.
5. Reset asserted in WAIT during a store to 0x20 of 0x55555555 -> the next load of 0x20 returns the old value. After reset, rsp_valid 0 and req_ready 1.
6. LATENCY = 0 back-to-back loads with rsp_ready tied high -> rsp_valid on the cycle after acceptance, one accepted request every 2 cycles.
